instruction_fetch: RTL
======================

Name: instruction_fetch

Overview:
- Fetch stage directly downstream of the program counter. Takes the current PC and issues in-order instruction-memory reads.
- Buffers returned instruction words together with their PCs and hands them to decode over a valid/ready handshake.
- Drives the PC register's enable and next-value inputs: sequential +4 advance, or a redirect from execute (branch/jump).
- Redirect flushes the buffer and discards in-flight responses.

Parameters:
FIFO_DEPTH, 2, number of instruction buffer entries and maximum outstanding memory reads; power of two, >= 2

Ports:
i_Clk  input  1  clock, rising edge
i_Rst_n  input  1  asynchronous reset, active low
i_PC  input  32  current PC from program counter register
o_PC_EN  output  1  PC register load enable
o_NewPC  output  32  value loaded into PC register when o_PC_EN=1
o_IMem_Req  output  1  read request valid
o_IMem_Addr  output  32  read address (equals i_PC)
i_IMem_Gnt  input  1  memory accepts request this cycle
i_IMem_RValid  input  1  read data valid; responses return in order, at least 1 cycle after grant
i_IMem_RData  input  32  read data
i_Redirect  input  1  flush and redirect, single-cycle pulse
i_RedirectPC  input  32  redirect target
o_Instr_Valid  output  1  instruction available to decode
o_Instr  output  32  instruction word
o_Instr_PC  output  32  PC of o_Instr
i_Instr_Ready  input  1  decode accepts instruction

Behaviour:
- State:
  - FIFO of FIFO_DEPTH entries {PC, data, filled}, with alloc, fill and head pointers.
  - Entry count C, 0..FIFO_DEPTH.
  - Outstanding counter O, 0..FIFO_DEPTH: granted requests not yet answered, including ones to be discarded.
  - Discard counter D <= O.
  - Counter width clog2(FIFO_DEPTH)+1.
- Reset (async, i_Rst_n=0): C=O=D=0, all pointers 0, all filled bits 0. Outputs: o_IMem_Req=0, o_PC_EN=0, o_Instr_Valid=0, o_NewPC=0.
- o_IMem_Req = !i_Redirect && C<FIFO_DEPTH && O<FIFO_DEPTH. o_IMem_Addr = i_PC.
- Grant (o_IMem_Req && i_IMem_Gnt):
  - allocate entry {PC=i_PC, filled=0} at alloc pointer; O+1.
  - o_PC_EN=1 and o_NewPC=i_PC+4, modulo 2^32, so 32'hFFFFFFFC wraps to 0.
  - PC register updates at that edge; i_PC shows the new value next cycle, so back-to-back grants fetch consecutive addresses.
- Response (i_IMem_RValid):
  - D>0: data dropped; D-1, O-1.
  - D=0: data written at fill pointer, filled=1, fill pointer advances; O-1.
  - RValid with O=0 is illegal and ignored.
- Decode output:
  - o_Instr_Valid = (head entry filled) && !i_Redirect. o_Instr and o_Instr_PC come from the head entry.
  - Pop on o_Instr_Valid && i_Instr_Ready: head advances, C-1.
  - Data is combinational from the FIFO. It may be presented the cycle after the response is written, not the same cycle.
- Redirect (i_Redirect=1), highest priority:
  - o_PC_EN=1, o_NewPC={i_RedirectPC[31:2],2'b00}; no request issued.
  - All entries flushed: C=0, pointers reset, filled bits cleared.
  - D_next = O - i_IMem_RValid, and O_next = O - i_IMem_RValid; a response arriving in the redirect cycle is dropped.
  - No pop occurs in a redirect cycle.
- Otherwise o_PC_EN=0, o_NewPC=0.
- Simultaneous grant, response and pop in one cycle: all three apply; C and O update by net amount.
- Full: C=FIFO_DEPTH or O=FIFO_DEPTH leads to o_IMem_Req=0 and PC held.
- Memory stalls (Req=1, Gnt=0): o_IMem_Addr stable, PC held.
- Reset asserted mid-operation clears everything immediately. Responses arriving after reset release with O=0 are ignored.

Test Plan:
- Reset then streaming: PC=0x100, Gnt=1 always, RValid 1 cycle after each grant, Ready=1 -> addresses 0x100,0x104,0x108...; decode gets the same PCs in order with matching data; o_NewPC=addr+4 each grant.
- Backpressure: Ready=0, DEPTH=2 -> exactly 2 grants, then Req=0 and PC held at 0x108. Raise Ready -> pops 0x100 then 0x104, fetch resumes at 0x108.
- Redirect with 2 outstanding: grant 0x200,0x204, no responses yet, then redirect to 0x403 -> o_NewPC=0x400, FIFO empty, next 2 responses dropped, first delivered instruction has PC 0x400.
- Redirect coincident with RValid and a full FIFO: that response is dropped, D=O-1, Instr_Valid=0 that cycle, no pop counted.
- Memory stall: Gnt=0 for 3 cycles -> Addr stable, o_PC_EN=0, no entries allocated; on Gnt, one allocation and PC+4.
- Wrap and async reset: PC=0xFFFFFFFC grant -> o_NewPC=0. Assert i_Rst_n=0 mid-burst -> outputs 0 immediately; stale RValid after release is ignored.

Source files
------------

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: issues in-order instruction-memory reads at the current PC,
// buffers returned words with their PCs, and hands them to decode over valid/ready.
module instruction_fetch #(
    parameter int FIFO_DEPTH = 2
) (
    input  logic        i_Clk,
    input  logic        i_Rst_n,
    input  logic [31:0] i_PC,
    output logic        o_PC_EN,
    output logic [31:0] o_NewPC,
    output logic        o_IMem_Req,
    output logic [31:0] o_IMem_Addr,
    input  logic        i_IMem_Gnt,
    input  logic        i_IMem_RValid,
    input  logic [31:0] i_IMem_RData,
    input  logic        i_Redirect,
    input  logic [31:0] i_RedirectPC,
    output logic        o_Instr_Valid,
    output logic [31:0] o_Instr,
    output logic [31:0] o_Instr_PC,
    input  logic        i_Instr_Ready
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] ZERO_C  = CW'(0);
    localparam logic [PW-1:0] PINC_C  = PW'(1);

    logic [31:0]           pc_r   [FIFO_DEPTH];
    logic [31:0]           data_r [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] filled_r;
    logic [PW-1:0]         alloc_ptr_r;
    logic [PW-1:0]         fill_ptr_r;
    logic [PW-1:0]         head_ptr_r;
    logic [CW-1:0]         cnt_r;
    logic [CW-1:0]         out_r;
    logic [CW-1:0]         disc_r;

    logic        req_s;
    logic        grant_s;
    logic        rsp_s;
    logic        drop_s;
    logic        write_s;
    logic        valid_s;
    logic        pop_s;
    logic        pc_en_s;
    logic [31:0] new_pc_s;

    // Request, response and pop qualification plus the PC register update.
    always_comb begin
        req_s    = 1'b0;
        pc_en_s  = 1'b0;
        new_pc_s = 32'd0;
        // Gating with i_Rst_n keeps the memory and PC interfaces quiet while held in reset.
        req_s    = i_Rst_n && !i_Redirect && (cnt_r < DEPTH_C) && (out_r < DEPTH_C);
        grant_s  = req_s && i_IMem_Gnt;
        // A response with nothing outstanding is spurious and is ignored.
        rsp_s    = i_IMem_RValid && (out_r != ZERO_C);
        drop_s   = rsp_s && (disc_r != ZERO_C);
        write_s  = rsp_s && (disc_r == ZERO_C) && !i_Redirect;
        valid_s  = filled_r[head_ptr_r] && !i_Redirect;
        pop_s    = valid_s && i_Instr_Ready;
        if (!i_Rst_n) begin
            pc_en_s  = 1'b0;
            new_pc_s = 32'd0;
        end else if (i_Redirect) begin
            pc_en_s  = 1'b1;
            new_pc_s = i_RedirectPC & 32'hFFFF_FFFC;
        end else if (grant_s) begin
            pc_en_s  = 1'b1;
            new_pc_s = i_PC + 32'd4;
        end else begin
            pc_en_s  = 1'b0;
            new_pc_s = 32'd0;
        end
    end

    assign o_IMem_Req    = req_s;
    assign o_IMem_Addr   = i_PC;
    assign o_PC_EN       = pc_en_s;
    assign o_NewPC       = new_pc_s;
    assign o_Instr_Valid = valid_s;
    assign o_Instr       = data_r[head_ptr_r];
    assign o_Instr_PC    = pc_r[head_ptr_r];

    // Instruction buffer, pointers and outstanding/discard bookkeeping.
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                pc_r[i]   <= 32'd0;
                data_r[i] <= 32'd0;
            end
            filled_r    <= '0;
            alloc_ptr_r <= '0;
            fill_ptr_r  <= '0;
            head_ptr_r  <= '0;
            cnt_r       <= ZERO_C;
            out_r       <= ZERO_C;
            disc_r      <= ZERO_C;
        end else if (i_Redirect) begin
            // Everything still in flight becomes stale; a response landing now is already dropped.
            filled_r    <= '0;
            alloc_ptr_r <= '0;
            fill_ptr_r  <= '0;
            head_ptr_r  <= '0;
            cnt_r       <= ZERO_C;
            out_r       <= out_r - CW'(rsp_s);
            disc_r      <= out_r - CW'(rsp_s);
        end else begin
            if (pop_s) begin
                filled_r[head_ptr_r] <= 1'b0;
                head_ptr_r           <= head_ptr_r + PINC_C;
            end
            if (grant_s) begin
                pc_r[alloc_ptr_r]     <= i_PC;
                filled_r[alloc_ptr_r] <= 1'b0;
                alloc_ptr_r           <= alloc_ptr_r + PINC_C;
            end
            if (write_s) begin
                data_r[fill_ptr_r]   <= i_IMem_RData;
                filled_r[fill_ptr_r] <= 1'b1;
                fill_ptr_r           <= fill_ptr_r + PINC_C;
            end
            cnt_r  <= cnt_r + CW'(grant_s) - CW'(pop_s);
            out_r  <= out_r + CW'(grant_s) - CW'(rsp_s);
            disc_r <= disc_r - CW'(drop_s);
        end
    end

endmodule
